// File: rtl/cpu_pkg.sv
// Shared constants for the CPU control unit: opcode fields, ALU operation
// codes and the sequencer state encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_IO_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  // ALU classes are recognised by opcode[5:3]; opcode[2:0] is the ALU op
  localparam logic [2:0] OP_ALU_R = 3'b000;
  localparam logic [2:0] OP_ALU_I = 3'b001;

  localparam logic [5:0] OP_J    = 6'b10_0000;
  localparam logic [5:0] OP_JZ   = 6'b10_0001;
  localparam logic [5:0] OP_JNZ  = 6'b10_0010;
  localparam logic [5:0] OP_JAL  = 6'b10_0011;
  localparam logic [5:0] OP_RET  = 6'b10_0100;
  localparam logic [5:0] OP_IN   = 6'b01_0000;
  localparam logic [5:0] OP_OUT  = 6'b01_0001;
  localparam logic [5:0] OP_HALT = 6'b11_1111;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_NOT_A  = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_NEG_A  = 3'b110;
  localparam logic [2:0] ALU_NEG_B  = 3'b111;

endpackage

// File: rtl/cpu_uc_if.sv
// Control-unit bundle: decode inputs from the datapath/bus and every
// datapath select, enable and status line driven back.
interface cpu_uc_if;
  logic [5:0] opcode;
  logic       z;
  logic       io_ack;

  logic       pc_en;
  logic       s_inc;
  logic       s_stack_mux;
  logic       push;
  logic       pop;
  logic       we3;
  logic       wez;
  logic       s_mux_alu;
  logic       s_mux_datos;
  logic       transceiver_oe;
  logic [2:0] op_alu;
  logic       io_req;
  logic       io_rnw;
  logic       halted;
  logic       stack_err;
  logic       bus_err;
  logic       illegal;

  modport master (
    input  opcode, z, io_ack,
    output pc_en, s_inc, s_stack_mux, push, pop, we3, wez, s_mux_alu,
           s_mux_datos, transceiver_oe, op_alu, io_req, io_rnw, halted,
           stack_err, bus_err, illegal
  );

  modport slave (
    output opcode, z, io_ack,
    input  pc_en, s_inc, s_stack_mux, push, pop, we3, wez, s_mux_alu,
           s_mux_datos, transceiver_oe, op_alu, io_req, io_rnw, halted,
           stack_err, bus_err, illegal
  );
endinterface

// File: rtl/cpu_uc_io_timer.sv
// I/O wait timer: counts IO_WAIT cycles from zero and flags the last
// permitted cycle before the transaction is abandoned.
module io_timer #(
  parameter int IO_TIMEOUT = 255,
  parameter int TO_W       = $clog2(IO_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(IO_TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/cpu_uc.sv
// Control unit for the single-ALU CPU: instruction decode, return-stack
// occupancy tracking, multi-cycle I/O handshake with timeout, and HALT.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | decode opcode, single-cycle instructions, issue I/O / HALT
// ST_IO_WAIT | hold io_req until io_ack or timeout, then resume
// ST_HALT    | all enables off, halted=1 until reset
module cpu_uc
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int IO_TIMEOUT  = 255,
  parameter int TO_W        = $clog2(IO_TIMEOUT + 1)
) (
  input  logic      clk,
  input  logic      reset,
  cpu_uc_if.master  bus
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  state_e          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            stack_err_q, stack_err_d;
  logic            bus_err_q, bus_err_d;
  logic            rnw_q, rnw_d;

  logic            tmr_clr, tmr_inc, tmr_expired;

  logic            pc_en_c, s_inc_c, s_stack_mux_c, push_c, pop_c;
  logic            we3_c, wez_c, s_mux_alu_c, s_mux_datos_c, oe_c;
  logic [2:0]      op_alu_c;
  logic            io_req_c, io_rnw_c, halted_c, illegal_c;

  io_timer #(
    .IO_TIMEOUT (IO_TIMEOUT),
    .TO_W       (TO_W)
  ) u_io_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (tmr_clr),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    stack_err_d   = stack_err_q;
    bus_err_d     = bus_err_q;
    rnw_d         = rnw_q;
    tmr_clr       = 1'b0;
    tmr_inc       = 1'b0;
    pc_en_c       = 1'b0;
    s_inc_c       = 1'b1;
    s_stack_mux_c = 1'b0;
    push_c        = 1'b0;
    pop_c         = 1'b0;
    we3_c         = 1'b0;
    wez_c         = 1'b0;
    s_mux_alu_c   = 1'b0;
    s_mux_datos_c = 1'b0;
    oe_c          = 1'b0;
    op_alu_c      = 3'b000;
    io_req_c      = 1'b0;
    io_rnw_c      = 1'b0;
    halted_c      = 1'b0;
    illegal_c     = 1'b0;

    case (state_q)
      ST_RUN: begin
        pc_en_c = 1'b1;
        if (bus.opcode[5:3] == OP_ALU_R || bus.opcode[5:3] == OP_ALU_I) begin
          op_alu_c    = bus.opcode[2:0];
          we3_c       = 1'b1;
          wez_c       = 1'b1;
          s_mux_alu_c = (bus.opcode[5:3] == OP_ALU_I);
        end else begin
          case (bus.opcode)
            OP_J:   s_inc_c = 1'b0;
            OP_JZ:  s_inc_c = ~bus.z;
            OP_JNZ: s_inc_c = bus.z;
            OP_JAL: begin
              if (depth_q < DEPTH_MAX) begin
                push_c  = 1'b1;
                s_inc_c = 1'b0;
                depth_d = depth_q + DW'(1);
              end else begin
                stack_err_d = 1'b1;
              end
            end
            OP_RET: begin
              if (depth_q != '0) begin
                pop_c         = 1'b1;
                s_stack_mux_c = 1'b1;
                depth_d       = depth_q - DW'(1);
              end else begin
                stack_err_d = 1'b1;
              end
            end
            OP_IN: begin
              io_req_c = 1'b1;
              io_rnw_c = 1'b1;
              pc_en_c  = 1'b0;
              tmr_clr  = 1'b1;
              rnw_d    = 1'b1;
              state_d  = ST_IO_WAIT;
            end
            OP_OUT: begin
              io_req_c = 1'b1;
              oe_c     = 1'b1;
              pc_en_c  = 1'b0;
              tmr_clr  = 1'b1;
              rnw_d    = 1'b0;
              state_d  = ST_IO_WAIT;
            end
            OP_HALT: begin
              pc_en_c = 1'b0;
              state_d = ST_HALT;
            end
            default: illegal_c = 1'b1;
          endcase
        end
      end

      ST_IO_WAIT: begin
        io_req_c = 1'b1;
        io_rnw_c = rnw_q;
        oe_c     = ~rnw_q;
        tmr_inc  = 1'b1;
        // an ack landing on the timeout cycle wins over the timeout
        if (bus.io_ack) begin
          pc_en_c       = 1'b1;
          we3_c         = rnw_q;
          s_mux_datos_c = rnw_q;
          state_d       = ST_RUN;
        end else if (tmr_expired) begin
          pc_en_c   = 1'b1;
          bus_err_d = 1'b1;
          state_d   = ST_RUN;
        end
      end

      ST_HALT: halted_c = 1'b1;

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      depth_q     <= '0;
      stack_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      rnw_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      stack_err_q <= stack_err_d;
      bus_err_q   <= bus_err_d;
      rnw_q       <= rnw_d;
    end
  end

  // Outputs are forced to their idle values while reset is held low
  assign bus.pc_en          = reset & pc_en_c;
  assign bus.s_inc          = ~reset | s_inc_c;
  assign bus.s_stack_mux    = reset & s_stack_mux_c;
  assign bus.push           = reset & push_c;
  assign bus.pop            = reset & pop_c;
  assign bus.we3            = reset & we3_c;
  assign bus.wez            = reset & wez_c;
  assign bus.s_mux_alu      = reset & s_mux_alu_c;
  assign bus.s_mux_datos    = reset & s_mux_datos_c;
  assign bus.transceiver_oe = reset & oe_c;
  assign bus.op_alu         = reset ? op_alu_c : 3'b000;
  assign bus.io_req         = reset & io_req_c;
  assign bus.io_rnw         = reset & io_rnw_c;
  assign bus.halted         = reset & halted_c;
  assign bus.stack_err      = reset & stack_err_q;
  assign bus.bus_err        = reset & bus_err_q;
  assign bus.illegal        = reset & illegal_c;

endmodule

// File: tb/tb_cpu_uc.sv
// Bench for cpu_uc: behavioural reference model compared on every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cpu_uc;

  localparam int SD = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  cpu_uc_if bus();

  cpu_uc #(.STACK_DEPTH(SD), .IO_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  int   m_mode = 0;       // 0 running, 1 waiting on bus, 2 halted
  int   m_depth = 0;
  bit   m_serr = 0, m_berr = 0, m_read = 0, m_valid = 0;
  int   m_waited = 0;

  function automatic logic [18:0] pack_dut();
    return {bus.pc_en, bus.s_inc, bus.s_stack_mux, bus.push, bus.pop,
            bus.we3, bus.wez, bus.s_mux_alu, bus.s_mux_datos,
            bus.transceiver_oe, bus.op_alu, bus.io_req, bus.io_rnw,
            bus.halted, bus.stack_err, bus.bus_err, bus.illegal};
  endfunction

  always @(negedge clk) begin : model_cmp
    bit pc_en, s_inc, smux, push, pop, we3, wez, salu, sdat, oe;
    bit req, rnw, hlt, ill;
    bit [2:0] alu;
    bit [5:0] op;
    logic [18:0] expv, actv;
    pc_en = 0; s_inc = 1; smux = 0; push = 0; pop = 0; we3 = 0; wez = 0;
    salu = 0; sdat = 0; oe = 0; req = 0; rnw = 0; hlt = 0; ill = 0; alu = 0;
    op = bus.opcode;
    expv = '0;
    if (reset === 1'b0) begin
      expv = {1'b0, 1'b1, 17'b0};
      actv = pack_dut();
      n_vec++;
      if (actv !== expv) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=%h", cyc, actv, expv);
      end
      m_mode = 0; m_depth = 0; m_serr = 0; m_berr = 0; m_valid = 1;
    end else if (m_valid) begin
      hlt = (m_mode == 2);
      if (m_mode == 0) begin
        pc_en = 1;
        if (op < 6'd16) begin
          alu = op % 8; we3 = 1; wez = 1; salu = (op >= 6'd8);
        end else if (op == 6'd32) s_inc = 0;
        else if (op == 6'd33) s_inc = !bus.z;
        else if (op == 6'd34) s_inc = bus.z;
        else if (op == 6'd35) begin
          if (m_depth < SD) begin push = 1; s_inc = 0; end
        end else if (op == 6'd36) begin
          if (m_depth > 0) begin pop = 1; smux = 1; end
        end else if (op == 6'd16 || op == 6'd17) begin
          pc_en = 0; req = 1; rnw = (op == 6'd16); oe = (op == 6'd17);
        end else if (op == 6'd63) pc_en = 0;
        else ill = 1;
      end else if (m_mode == 1) begin
        req = 1; rnw = m_read; oe = !m_read;
        if (bus.io_ack) begin pc_en = 1; we3 = m_read; sdat = m_read; end
        else if (m_waited == TO - 1) pc_en = 1;
      end
      expv = {pc_en, s_inc, smux, push, pop, we3, wez, salu, sdat, oe, alu,
              req, rnw, hlt, m_serr, m_berr, ill};
      actv = pack_dut();
      n_vec++;
      if (actv !== expv) begin
        n_err++;
        $display("FAIL model_outputs cyc=%0d op=%b got=%h want=%h", cyc, op, actv, expv);
      end
      // advance model (inputs stay stable until after the next rising edge)
      if (m_mode == 0) begin
        if (op == 6'd35) begin
          if (m_depth < SD) m_depth++; else m_serr = 1;
        end else if (op == 6'd36) begin
          if (m_depth > 0) m_depth--; else m_serr = 1;
        end else if (op == 6'd16 || op == 6'd17) begin
          m_mode = 1; m_read = (op == 6'd16); m_waited = 0;
        end else if (op == 6'd63) m_mode = 2;
      end else if (m_mode == 1) begin
        if (bus.io_ack) m_mode = 0;
        else if (m_waited == TO - 1) begin m_mode = 0; m_berr = 1; end
        else m_waited++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply(input logic [5:0] op, input logic zz, input logic ack,
                       input logic rst);
    @(posedge clk);
    #1;
    bus.opcode = op; bus.z = zz; bus.io_ack = ack; reset = rst;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  int cnt_a, cnt_b;

  initial begin
    bus.opcode = 6'd0; bus.z = 1'b0; bus.io_ack = 1'b0;
    repeat (3) apply(6'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_pc_en", bus.pc_en, 0);
    chk("rst_s_inc", bus.s_inc, 1);

    apply(6'b001010, 1'b0, 1'b0, 1'b1);
    chk("alui_op", bus.op_alu, 3'b010);
    chk("alui_en", {bus.we3, bus.wez, bus.pc_en, bus.s_mux_alu}, 4'b1111);
    apply(6'b000011, 1'b0, 1'b0, 1'b1);
    chk("alur_op", bus.op_alu, 3'b011);
    chk("alur_en", {bus.we3, bus.wez, bus.pc_en, bus.s_mux_alu}, 4'b1110);

    apply(6'b100001, 1'b1, 1'b0, 1'b1);
    chk("jz_z1", bus.s_inc, 0);
    apply(6'b100001, 1'b0, 1'b0, 1'b1);
    chk("jz_z0", bus.s_inc, 1);
    apply(6'b100010, 1'b0, 1'b0, 1'b1);
    chk("jnz_z0", bus.s_inc, 0);

    cnt_a = 0;
    for (int i = 0; i < 17; i++) begin
      apply(6'b100011, 1'($urandom), 1'b0, 1'b1);
      if (bus.push) cnt_a++;
    end
    chk("jal_pushes", cnt_a, 16);
    chk("jal_full", {bus.push, bus.s_inc}, 2'b01);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 17; i++) begin
      apply(6'b100100, 1'($urandom), 1'b0, 1'b1);
      if (i == 0) chk("stack_err_set", bus.stack_err, 1);
      if (bus.pop) cnt_a++;
      if (bus.s_stack_mux) cnt_b++;
    end
    chk("ret_pops", cnt_a, 16);
    chk("ret_smux", cnt_b, 16);
    chk("ret_empty", {bus.pop, bus.s_inc, bus.stack_err}, 3'b011);

    cnt_a = 0;
    apply(6'b010000, 1'b0, 1'b0, 1'b1);
    if (!bus.pc_en) cnt_a++;
    for (int i = 0; i < 2; i++) begin
      apply(6'($urandom), 1'b0, 1'b0, 1'b1);
      if (!bus.pc_en) cnt_a++;
    end
    chk("in_stall", cnt_a, 3);
    apply(6'($urandom), 1'b0, 1'b1, 1'b1);
    chk("in_done", {bus.we3, bus.s_mux_datos, bus.pc_en}, 3'b111);

    cnt_a = 0;
    apply(6'b010001, 1'b0, 1'b0, 1'b1);
    if (bus.io_req && bus.transceiver_oe) cnt_a++;
    for (int i = 0; i < 4; i++) begin
      apply(6'($urandom), 1'b0, 1'b0, 1'b1);
      if (bus.io_req && bus.transceiver_oe) cnt_a++;
    end
    chk("out_req_cycles", cnt_a, 5);
    chk("out_timeout", {bus.pc_en, bus.we3}, 2'b10);
    apply(6'b000000, 1'b0, 1'b0, 1'b1);
    chk("bus_err_set", {bus.bus_err, bus.io_req}, 2'b10);

    apply(6'd0, 1'b0, 1'b0, 1'b0);
    apply(6'b010001, 1'b0, 1'b0, 1'b1);
    apply(6'd0, 1'b0, 1'b0, 1'b1);
    apply(6'd0, 1'b0, 1'b0, 1'b0);
    apply(6'd0, 1'b0, 1'b0, 1'b0);
    chk("io_rst_req", {bus.io_req, bus.bus_err, bus.we3}, 3'b000);
    apply(6'b100000, 1'b0, 1'b1, 1'b1);
    chk("io_rst_after", {bus.io_req, bus.bus_err, bus.we3, bus.s_inc}, 4'b0000);

    apply(6'b110101, 1'b0, 1'b0, 1'b1);
    chk("illegal", {bus.illegal, bus.pc_en, bus.s_inc}, 3'b111);
    apply(6'b111111, 1'b0, 1'b0, 1'b1);
    chk("halt_issue", bus.pc_en, 0);
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      apply(6'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      if (bus.halted && !bus.pc_en) cnt_a++;
    end
    chk("halt_hold", cnt_a, 10);
    apply(6'd0, 1'b0, 1'b0, 1'b0);
    apply(6'b000101, 1'b0, 1'b0, 1'b1);
    chk("halt_exit", {bus.halted, bus.pc_en, bus.op_alu}, 5'b01101);

    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 9))
        0, 1: op = 6'($urandom_range(0, 15));
        2:    op = 6'b100011;
        3:    op = 6'b100100;
        4:    op = 6'($urandom_range(32, 34));
        5:    op = 6'($urandom_range(16, 17));
        6:    op = ($urandom_range(0, 19) == 0) ? 6'b111111 : 6'b100011;
        7:    op = 6'b100100;
        default: op = 6'($urandom);
      endcase
      apply(op, 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 79) != 0));
    end

    apply(6'd0, 1'b0, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
